// File: rtl/dqn_env_pkg.sv
// rtl/dqn_env_pkg.sv - shared grid-world constants, action encodings and stepper FSM states
package dqn_env_pkg;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_RIGHT = 2'd1;
    localparam logic [1:0] ACT_DOWN  = 2'd2;
    localparam logic [1:0] ACT_LEFT  = 2'd3;

    localparam int         GRID_W     = 4;
    localparam logic [3:0] GOAL_STATE = 4'd9;
    localparam logic [3:0] HAZARD_5   = 4'd5;
    localparam logic [3:0] HAZARD_7   = 4'd7;
    localparam logic [3:0] HAZARD_8   = 4'd8;
    localparam logic [3:0] MAX_STEP   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACT = 2'd1,
        S_MOVE     = 2'd2,
        S_OUT      = 2'd3
    } step_state_t;

endpackage

// File: rtl/grid_move.sv
// rtl/grid_move.sv - combinational 4x4 grid move with wall clamping
module grid_move
    import dqn_env_pkg::*;
(
    input  logic [3:0] state,
    input  logic [1:0] action,
    output logic [3:0] next_state
);

    logic [1:0] row;
    logic [1:0] col;

    assign row = state[3:2];
    assign col = state[1:0];

    // A blocked move leaves the state unchanged; the reward stage penalises the bump.
    always_comb begin
        next_state = state;
        case (action)
            ACT_UP:    if (row != 2'd0) next_state = state - 4'd4;
            ACT_DOWN:  if (row != 2'd3) next_state = state + 4'd4;
            ACT_LEFT:  if (col != 2'd0) next_state = state - 4'd1;
            ACT_RIGHT: if (col != 2'd3) next_state = state + 4'd1;
            default:   next_state = state;
        endcase
    end

endmodule

// File: rtl/grid_env_stepper.sv
// rtl/grid_env_stepper.sv - grid-world environment stepper: action in, registered transition out
module grid_env_stepper
    import dqn_env_pkg::*;
#(
    parameter logic [3:0] START_STATE = 4'd0,
    parameter logic [3:0] GOAL_STATE  = dqn_env_pkg::GOAL_STATE,
    parameter logic [3:0] MAX_STEP    = dqn_env_pkg::MAX_STEP,
    parameter int         EP_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            action_valid,
    input  logic [1:0]      action,
    output logic            action_ready,
    output logic            trans_valid,
    input  logic            trans_ready,
    output logic [3:0]      st,
    output logic [3:0]      st1,
    output logic [3:0]      step,
    output logic            done,
    output logic [EP_W-1:0] episode_count
);

    step_state_t state;
    logic [3:0]  cur_state;
    logic [3:0]  step_cnt;
    logic [1:0]  act_q;
    logic [3:0]  st1_next;

    grid_move u_move (
        .state      (cur_state),
        .action     (act_q),
        .next_state (st1_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cur_state     <= START_STATE;
            step_cnt      <= 4'd0;
            act_q         <= ACT_UP;
            action_ready  <= 1'b0;
            trans_valid   <= 1'b0;
            st            <= 4'd0;
            st1           <= 4'd0;
            step          <= 4'd0;
            done          <= 1'b0;
            episode_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_state    <= START_STATE;
                        step_cnt     <= 4'd0;
                        action_ready <= 1'b1;
                        state        <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (action_valid && action_ready) begin
                        act_q        <= action;
                        action_ready <= 1'b0;
                        state        <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    st          <= cur_state;
                    st1         <= st1_next;
                    step        <= step_cnt;
                    done        <= (st1_next == GOAL_STATE) || (step_cnt == MAX_STEP);
                    trans_valid <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    // Transition fields stay frozen until the reward stage takes them.
                    if (trans_ready) begin
                        trans_valid  <= 1'b0;
                        action_ready <= 1'b1;
                        state        <= S_WAIT_ACT;
                        if (done) begin
                            episode_count <= episode_count + EP_W'(1);
                            cur_state     <= START_STATE;
                            step_cnt      <= 4'd0;
                        end else begin
                            cur_state <= st1;
                            step_cnt  <= step_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_env_stepper.sv
// tb/tb_grid_env_stepper.sv - self-checking bench for grid_env_stepper
module tb_grid_env_stepper;
    import dqn_env_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       action_valid = 1'b0;
    logic [1:0] action = 2'd0;
    logic       action_ready;
    logic       trans_valid;
    logic       trans_ready = 1'b0;
    logic [3:0] st, st1, step;
    logic       done;
    logic [7:0] episode_count;

    grid_env_stepper dut (
        .clk(clk), .rst(rst), .start(start),
        .action_valid(action_valid), .action(action), .action_ready(action_ready),
        .trans_valid(trans_valid), .trans_ready(trans_ready),
        .st(st), .st1(st1), .step(step), .done(done),
        .episode_count(episode_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [3:0] st1;
        logic [3:0] step;
        logic       done;
    } trans_t;

    typedef struct {
        logic       rst_first;
        logic [1:0] act;
        trans_t     exp;
    } vec_t;

    trans_t sb_q[$];
    vec_t   vecs[5];
    int     errors = 0;
    int     checks = 0;
    int     ep_exp = 0;
    logic [3:0] m_cur;
    logic [3:0] m_step;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic [1:0] a);
        int r = int'(s) / 4;
        int c = int'(s) % 4;
        case (a)
            2'd0: if (r > 0) r--;
            2'd1: if (c < 3) c++;
            2'd2: if (r < 3) r++;
            default: if (c > 0) c--;
        endcase
        return 4'(r * 4 + c);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_trans_valid"}, trans_valid, 0);
        chk({tag, "_action_ready"}, action_ready, 0);
        chk({tag, "_st"}, st, 0);
        chk({tag, "_st1"}, st1, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_episode_count"}, episode_count, 0);
    endtask

    task automatic reset_and_start();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ep_exp = 0;
        check_idle_outputs("reset");
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left on a falling edge; hold>0 stalls the consumer with action_valid high.
    task automatic do_step(input logic [1:0] a, input trans_t exp, input int hold);
        int     lat;
        trans_t got;
        logic [3:0] h_st, h_st1, h_step;
        logic       h_done;
        chk("ready_before_action", action_ready, 1);
        action_valid = 1'b1;
        action = a;
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        action_valid = 1'b0;
        chk("ready_after_accept", action_ready, 0);
        lat = 1;
        while (!trans_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("trans_latency", lat, 2);
        h_st = st; h_st1 = st1; h_step = step; h_done = done;
        for (int i = 0; i < hold; i++) begin
            action_valid = 1'b1;
            action = ~a;
            @(negedge clk);
            chk("hold_trans_valid", trans_valid, 1);
            chk("hold_action_ready", action_ready, 0);
            chk("hold_st", st, h_st);
            chk("hold_st1", st1, h_st1);
            chk("hold_step", step, h_step);
            chk("hold_done", done, h_done);
        end
        action_valid = 1'b0;
        trans_ready = 1'b1;
        if (trans_valid && sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk("st", st, got.st);
            chk("st1", st1, got.st1);
            chk("step", step, got.step);
            chk("done", done, got.done);
        end else begin
            chk("scoreboard_pop", trans_valid, 1);
            sb_q.delete();
        end
        if (exp.done) ep_exp++;
        @(posedge clk);
        @(negedge clk);
        trans_ready = 1'b0;
        chk("valid_after_release", trans_valid, 0);
        chk("ready_after_release", action_ready, 1);
        chk("episode_count", episode_count, ep_exp);
    endtask

    task automatic model_step(input logic [1:0] a);
        trans_t e;
        e.st   = m_cur;
        e.st1  = model_next(m_cur, a);
        e.step = m_step;
        e.done = (e.st1 == 4'd9) || (m_step == 4'd15);
        do_step(a, e, 0);
        if (e.done) begin
            m_cur = 4'd0;
            m_step = 4'd0;
        end else begin
            m_cur = e.st1;
            m_step = m_step + 4'd1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rst_first: 1'b1, act: ACT_RIGHT, exp: '{st: 4'd0, st1: 4'd1, step: 4'd0, done: 1'b0}};
        vecs[1] = '{rst_first: 1'b1, act: ACT_UP,    exp: '{st: 4'd0, st1: 4'd0, step: 4'd0, done: 1'b0}};
        vecs[2] = '{rst_first: 1'b1, act: ACT_RIGHT, exp: '{st: 4'd0, st1: 4'd1, step: 4'd0, done: 1'b0}};
        vecs[3] = '{rst_first: 1'b0, act: ACT_DOWN,  exp: '{st: 4'd1, st1: 4'd5, step: 4'd1, done: 1'b0}};
        vecs[4] = '{rst_first: 1'b0, act: ACT_DOWN,  exp: '{st: 4'd5, st1: 4'd9, step: 4'd2, done: 1'b1}};

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rst_first) reset_and_start();
            do_step(vecs[i].act, vecs[i].exp, 0);
        end

        // Sixteen LEFT bumps from the start corner: only the last step ends the episode.
        for (int i = 0; i < 16; i++) begin
            trans_t e;
            e = '{st: 4'd0, st1: 4'd0, step: 4'(i), done: (i == 15)};
            do_step(ACT_LEFT, e, 0);
        end
        chk("episode_after_timeout", episode_count, 2);

        // Consumer stall with a persistent action request; nothing extra may be captured.
        do_step(ACT_RIGHT, '{st: 4'd0, st1: 4'd1, step: 4'd0, done: 1'b0}, 5);
        repeat (3) @(negedge clk);
        chk("no_second_capture", trans_valid, 0);

        // Goal reached exactly on the last step counts one episode.
        reset_and_start();
        m_cur = 4'd0;
        m_step = 4'd0;
        repeat (13) model_step(ACT_UP);
        model_step(ACT_RIGHT);
        model_step(ACT_DOWN);
        model_step(ACT_DOWN);
        chk("goal_on_max_step_episodes", episode_count, 1);
        chk("goal_on_max_step_restart", m_step, 0);

        // Reset while a transition is waiting for the consumer.
        model_step(ACT_DOWN);
        action_valid = 1'b1;
        action = ACT_RIGHT;
        @(posedge clk);
        @(negedge clk);
        action_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", trans_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        action_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ignores_action", trans_valid | action_ready, 0);
        end
        action_valid = 1'b0;
        ep_exp = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_cur = 4'd0;
        m_step = 4'd0;
        model_step(ACT_RIGHT);

        // Random walk against the reference model, crossing hazards and episode restarts.
        for (int i = 0; i < 40; i++) model_step(2'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
